// File: rtl/jtag_tap_oversampled_if.sv
// JTAG pin bundle between a probe (master) and the oversampled TAP (slave).
interface jtag_tap_oversampled_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, tms, tdi, input tdo, tdo_oe);
  modport slave  (input tck, tms, tdi, output tdo, tdo_oe);
endinterface

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP slave running entirely in the clk domain: tck/tms/tdi are synchronised,
// tck edges are detected by oversampling, and all TAP state advances on those edges.
module jtag_tap_oversampled #(
  parameter int unsigned         IR_WIDTH     = 6,
  parameter int unsigned         DR_WIDTH     = 32,
  parameter int unsigned         NUM_CHAN     = 4,
  parameter int unsigned         SYNC_STAGES  = 2,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE    = 6'b001001,
  parameter logic [IR_WIDTH-1:0] IR_USER_BASE = 6'b000010,
  parameter logic [31:0]         IDCODE       = 32'h0A001093,
  localparam int unsigned        CHAN_W       = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  jtag_tap_oversampled_if.slave        jtag,
  output logic [3:0]                   tap_state,
  input  logic [NUM_CHAN*DR_WIDTH-1:0] cap_data,
  output logic [NUM_CHAN-1:0]          cap_strobe,
  output logic [DR_WIDTH-1:0]          upd_data,
  output logic [CHAN_W-1:0]            upd_chan,
  output logic                         upd_valid
);

  typedef enum logic [3:0] {
    TLR      = 4'hF, RTI      = 4'hC,
    SEL_DR   = 4'h7, CAP_DR   = 4'h6, SHIFT_DR = 4'h2, EXIT1_DR = 4'h1,
    PAUSE_DR = 4'h3, EXIT2_DR = 4'h0, UPD_DR   = 4'h5,
    SEL_IR   = 4'h4, CAP_IR   = 4'hE, SHIFT_IR = 4'hA, EXIT1_IR = 4'h9,
    PAUSE_IR = 4'hB, EXIT2_IR = 4'h8, UPD_IR   = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_e;

  typedef struct packed {
    logic tck;
    logic tms;
    logic tdi;
  } pins_t;

  localparam int unsigned MASK_MAX = SYNC_STAGES + 1;
  localparam int unsigned MASK_W   = $clog2(SYNC_STAGES + 2);

  pins_t                sync_q [SYNC_STAGES];
  pins_t                sync_d [SYNC_STAGES];
  logic                 tck_prev_q, tck_prev_d;
  logic [MASK_W-1:0]    mask_cnt_q, mask_cnt_d;
  tap_state_e           state_q, state_d, state_nxt;
  logic [IR_WIDTH-1:0]  ir_q, ir_d;
  logic [IR_WIDTH-1:0]  ir_sr_q, ir_sr_d;
  logic                 bypass_q, bypass_d;
  logic [31:0]          idcode_sr_q, idcode_sr_d;
  logic [DR_WIDTH-1:0]  chan_sr_q [NUM_CHAN];
  logic [DR_WIDTH-1:0]  chan_sr_d [NUM_CHAN];
  logic                 tdo_q, tdo_d;
  logic                 tdo_oe_q, tdo_oe_d;
  logic [NUM_CHAN-1:0]  cap_strobe_q, cap_strobe_d;
  logic [DR_WIDTH-1:0]  upd_data_q, upd_data_d;
  logic [CHAN_W-1:0]    upd_chan_q, upd_chan_d;
  logic                 upd_valid_q, upd_valid_d;

  pins_t                pins_s;
  logic                 armed;
  logic                 rise;
  logic                 fall;
  dr_sel_e              dr_sel;
  logic [CHAN_W-1:0]    sel_chan;
  logic [IR_WIDTH-1:0]  user_off;

  // Synchroniser chain and tck edge detection, masked until the chain has refilled.
  always_comb begin
    sync_d[0] = {jtag.tck, jtag.tms, jtag.tdi};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    pins_s     = sync_q[SYNC_STAGES-1];
    armed      = (mask_cnt_q == MASK_W'(MASK_MAX));
    mask_cnt_d = armed ? mask_cnt_q : mask_cnt_q + 1'b1;
    tck_prev_d = pins_s.tck;
    rise       = armed &  pins_s.tck & ~tck_prev_q;
    fall       = armed & ~pins_s.tck &  tck_prev_q;
  end

  // Instruction decode; out-of-range user codes wrap to large offsets and fall to BYPASS.
  always_comb begin
    user_off = ir_q - IR_USER_BASE;
    dr_sel   = SEL_BYPASS;
    sel_chan = '0;
    if (ir_q == '1) begin
      dr_sel = SEL_BYPASS;
    end else if (ir_q == IR_IDCODE) begin
      dr_sel = SEL_IDCODE;
    end else if (32'(user_off) < NUM_CHAN) begin
      dr_sel   = SEL_USER;
      sel_chan = CHAN_W'(user_off);
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:      state_nxt = pins_s.tms ? TLR      : RTI;
      RTI:      state_nxt = pins_s.tms ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = pins_s.tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = pins_s.tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nxt = pins_s.tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nxt = pins_s.tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = pins_s.tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nxt = pins_s.tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_nxt = pins_s.tms ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = pins_s.tms ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = pins_s.tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nxt = pins_s.tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nxt = pins_s.tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = pins_s.tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nxt = pins_s.tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_nxt = pins_s.tms ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d      = state_q;
    ir_d         = ir_q;
    ir_sr_d      = ir_sr_q;
    bypass_d     = bypass_q;
    idcode_sr_d  = idcode_sr_q;
    chan_sr_d    = chan_sr_q;
    tdo_d        = tdo_q;
    tdo_oe_d     = tdo_oe_q;
    cap_strobe_d = '0;
    upd_data_d   = upd_data_q;
    upd_chan_d   = upd_chan_q;
    upd_valid_d  = 1'b0;

    if (rise) begin
      state_d = state_nxt;
      if (state_q == SHIFT_DR) begin
        case (dr_sel)
          SEL_IDCODE: idcode_sr_d = {pins_s.tdi, idcode_sr_q[31:1]};
          SEL_USER:   chan_sr_d[sel_chan] = {pins_s.tdi, chan_sr_q[sel_chan][DR_WIDTH-1:1]};
          default:    bypass_d = pins_s.tdi;
        endcase
      end
      if (state_q == SHIFT_IR) ir_sr_d = {pins_s.tdi, ir_sr_q[IR_WIDTH-1:1]};

      // Capture and update act on entry to their states, so strobes align with tap_state.
      case (state_nxt)
        CAP_DR: begin
          bypass_d    = 1'b0;
          idcode_sr_d = IDCODE;
          if (dr_sel == SEL_USER) begin
            chan_sr_d[sel_chan]    = cap_data[32'(sel_chan) * DR_WIDTH +: DR_WIDTH];
            cap_strobe_d[sel_chan] = 1'b1;
          end
        end
        CAP_IR: ir_sr_d = IR_WIDTH'(1);
        UPD_IR: ir_d = ir_sr_q;
        UPD_DR: begin
          if (dr_sel == SEL_USER) begin
            upd_data_d  = chan_sr_q[sel_chan];
            upd_chan_d  = sel_chan;
            upd_valid_d = 1'b1;
          end
        end
        TLR:     ir_d = IR_IDCODE;
        default: ;
      endcase
    end

    if (fall) begin
      tdo_oe_d = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
      if (state_q == SHIFT_IR) begin
        tdo_d = ir_sr_q[0];
      end else begin
        case (dr_sel)
          SEL_IDCODE: tdo_d = idcode_sr_q[0];
          SEL_USER:   tdo_d = chan_sr_q[sel_chan][0];
          default:    tdo_d = bypass_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the channel register array is reset because its contents are visible on tdo.
      sync_q       <= '{default: '0};
      tck_prev_q   <= 1'b0;
      mask_cnt_q   <= '0;
      state_q      <= TLR;
      ir_q         <= IR_IDCODE;
      ir_sr_q      <= '0;
      bypass_q     <= 1'b0;
      idcode_sr_q  <= '0;
      chan_sr_q    <= '{default: '0};
      tdo_q        <= 1'b0;
      tdo_oe_q     <= 1'b0;
      cap_strobe_q <= '0;
      upd_data_q   <= '0;
      upd_chan_q   <= '0;
      upd_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync_q       <= sync_d;
      tck_prev_q   <= tck_prev_d;
      mask_cnt_q   <= mask_cnt_d;
      state_q      <= state_d;
      ir_q         <= ir_d;
      ir_sr_q      <= ir_sr_d;
      bypass_q     <= bypass_d;
      idcode_sr_q  <= idcode_sr_d;
      chan_sr_q    <= chan_sr_d;
      tdo_q        <= tdo_d;
      tdo_oe_q     <= tdo_oe_d;
      cap_strobe_q <= cap_strobe_d;
      upd_data_q   <= upd_data_d;
      upd_chan_q   <= upd_chan_d;
      upd_valid_q  <= upd_valid_d;
    end
  end

  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_oe = tdo_oe_q;
  assign tap_state   = state_q;
  assign cap_strobe  = cap_strobe_q;
  assign upd_data    = upd_data_q;
  assign upd_chan    = upd_chan_q;
  assign upd_valid   = upd_valid_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Directed bench for jtag_tap_oversampled plus a jittered random walk against a TAP model.
module tb_jtag_tap_oversampled;

  localparam int          DR_W   = 32;
  localparam int          NCH    = 4;
  localparam int          HALF   = 5;
  localparam logic [5:0]  IR_IDC = 6'b001001;
  localparam logic [31:0] IDC    = 32'h0A001093;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6,
                         S_SHDR = 4'h2, S_E1DR = 4'h1, S_PDR = 4'h3, S_E2DR = 4'h0,
                         S_UDR = 4'h5, S_SIR = 4'h4, S_CIR = 4'hE, S_SHIR = 4'hA,
                         S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8, S_UIR = 4'hD;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [3:0]          tap_state;
  logic [NCH*DR_W-1:0] cap_data;
  logic [NCH-1:0]      cap_strobe;
  logic [DR_W-1:0]     upd_data;
  logic [1:0]          upd_chan;
  logic                upd_valid;

  jtag_tap_oversampled_if jtag();

  jtag_tap_oversampled dut (
    .clk        (clk),
    .reset      (reset),
    .jtag       (jtag),
    .tap_state  (tap_state),
    .cap_data   (cap_data),
    .cap_strobe (cap_strobe),
    .upd_data   (upd_data),
    .upd_chan   (upd_chan),
    .upd_valid  (upd_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitors on the fabric side.
  int             cap_n = 0;
  int             upd_n = 0;
  int             cap_ch_n [NCH];
  logic [NCH-1:0] cap_last = '0;

  initial for (int i = 0; i < NCH; i++) cap_ch_n[i] = 0;

  always @(negedge clk) begin
    if (cap_strobe != '0) begin
      cap_n++;
      cap_last = cap_strobe;
      for (int i = 0; i < NCH; i++) if (cap_strobe[i]) cap_ch_n[i]++;
    end
    if (upd_valid) upd_n++;
  end

  // Reference TAP model, advanced on every tck edge the bench produces.
  logic [3:0]  m_state;
  logic [5:0]  m_ir, m_irsr;
  logic        m_byp, m_tdo, m_oe;
  logic [31:0] m_id, m_upd;
  logic [31:0] m_ch [NCH];
  int          m_upd_n = 0;
  int          m_cap_n [NCH];

  initial for (int i = 0; i < NCH; i++) m_cap_n[i] = 0;

  task automatic model_reset();
    m_state = S_TLR; m_ir = IR_IDC; m_irsr = '0; m_byp = 1'b0;
    m_id = '0; m_upd = '0; m_tdo = 1'b0; m_oe = 1'b0;
    for (int i = 0; i < NCH; i++) m_ch[i] = '0;
  endtask

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      S_TLR:   return t ? S_TLR  : S_RTI;
      S_RTI:   return t ? S_SDR  : S_RTI;
      S_SDR:   return t ? S_SIR  : S_CDR;
      S_CDR:   return t ? S_E1DR : S_SHDR;
      S_SHDR:  return t ? S_E1DR : S_SHDR;
      S_E1DR:  return t ? S_UDR  : S_PDR;
      S_PDR:   return t ? S_E2DR : S_PDR;
      S_E2DR:  return t ? S_UDR  : S_SHDR;
      S_UDR:   return t ? S_SDR  : S_RTI;
      S_SIR:   return t ? S_TLR  : S_CIR;
      S_CIR:   return t ? S_E1IR : S_SHIR;
      S_SHIR:  return t ? S_E1IR : S_SHIR;
      S_E1IR:  return t ? S_UIR  : S_PIR;
      S_PIR:   return t ? S_E2IR : S_PIR;
      S_E2IR:  return t ? S_UIR  : S_SHIR;
      S_UIR:   return t ? S_SDR  : S_RTI;
      default: return S_TLR;
    endcase
  endfunction

  // -1 = IDCODE, -2 = BYPASS, 0..3 = user channel.
  function automatic int sel_of(input logic [5:0] ir);
    if (ir == 6'h3F) return -2;
    if (ir == IR_IDC) return -1;
    if (ir >= 6'd2 && ir <= 6'd5) return int'(ir) - 2;
    return -2;
  endfunction

  task automatic model_rise(input logic t_ms, input logic t_di);
    int k;
    logic [3:0] nx;
    k = sel_of(m_ir);
    if (m_state == S_SHDR) begin
      if (k == -1)      m_id = {t_di, m_id[31:1]};
      else if (k == -2) m_byp = t_di;
      else              m_ch[k] = {t_di, m_ch[k][31:1]};
    end
    if (m_state == S_SHIR) m_irsr = {t_di, m_irsr[5:1]};
    nx = tap_next(m_state, t_ms);
    case (nx)
      S_CDR: begin
        m_byp = 1'b0;
        m_id  = IDC;
        if (k >= 0) begin
          m_ch[k] = cap_data[k*DR_W +: DR_W];
          m_cap_n[k]++;
        end
      end
      S_CIR: m_irsr = 6'b000001;
      S_UIR: m_ir = m_irsr;
      S_UDR: if (k >= 0) begin m_upd = m_ch[k]; m_upd_n++; end
      S_TLR: m_ir = IR_IDC;
      default: ;
    endcase
    m_state = nx;
  endtask

  task automatic model_fall();
    int k;
    k = sel_of(m_ir);
    m_oe = (m_state == S_SHDR) || (m_state == S_SHIR);
    if (m_state == S_SHIR) m_tdo = m_irsr[0];
    else if (k == -1)      m_tdo = m_id[0];
    else if (k == -2)      m_tdo = m_byp;
    else                   m_tdo = m_ch[k][0];
  endtask

  // One tck cycle: sample tdo/tdo_oe left by the previous fall, then drive and pulse tck.
  task automatic step(input logic t_ms, input logic t_di, output logic t_do, output logic t_oe);
    t_do = jtag.tdo;
    t_oe = jtag.tdo_oe;
    jtag.tms = t_ms;
    jtag.tdi = t_di;
    repeat (HALF) @(negedge clk);
    jtag.tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (HALF) @(negedge clk);
    jtag.tck = 1'b0;
    model_fall();
    repeat (HALF) @(negedge clk);
  endtask

  // From Run-Test/Idle, shift n bits through the DR and return to Run-Test/Idle.
  task automatic shift_dr(input logic [31:0] val, input int n, output logic [31:0] out,
                          output logic oe_in, output logic oe_out);
    logic d, oe;
    out = '0;
    oe_in = 1'b1;
    step(1'b1, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
    oe_out = oe;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, val[i], d, oe);
      out[i] = d;
      oe_in  = oe_in & oe;
    end
    step(1'b1, 1'b0, d, oe);
    oe_out = oe_out | oe;
    step(1'b0, 1'b0, d, oe);
  endtask

  task automatic shift_ir(input logic [5:0] val, output logic [5:0] out);
    logic d, oe;
    out = '0;
    step(1'b1, 1'b0, d, oe);
    step(1'b1, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
    for (int i = 0; i < 6; i++) begin
      step(i == 5, val[i], d, oe);
      out[i] = d;
    end
    step(1'b1, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
  endtask

  task automatic wait_jit();
    repeat ($urandom_range(3, 2)) @(negedge clk);
    #($urandom_range(3, 0));
  endtask

  // Random step with a roughly clk/4 tck and jittered edges, then compare after settling.
  task automatic rstep(input int idx, input logic t_ms, input logic t_di);
    @(negedge clk);
    jtag.tms = t_ms;
    jtag.tdi = t_di;
    wait_jit();
    jtag.tck = 1'b1;
    model_rise(t_ms, t_di);
    wait_jit();
    jtag.tck = 1'b0;
    model_fall();
    repeat (5) @(negedge clk);
    check($sformatf("rnd%0d_state", idx), 32'(tap_state), 32'(m_state));
    check($sformatf("rnd%0d_tdo", idx), 32'(jtag.tdo), 32'(m_tdo));
    check($sformatf("rnd%0d_oe", idx), 32'(jtag.tdo_oe), 32'(m_oe));
    check($sformatf("rnd%0d_upd", idx), upd_data, m_upd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] out;
    logic [5:0]  ir_out;
    logic        oe_in, oe_out, d, oe;
    int          cap0, upd0;

    jtag.tck = 1'b0;
    jtag.tms = 1'b1;
    jtag.tdi = 1'b0;
    cap_data = '0;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    check("rst_state", 32'(tap_state), 32'hF);
    check("rst_tdo", 32'(jtag.tdo), 32'h0);
    check("rst_oe", 32'(jtag.tdo_oe), 32'h0);
    check("rst_cap", 32'(cap_strobe), 32'h0);
    check("rst_updv", 32'(upd_valid), 32'h0);
    check("rst_upd", upd_data, 32'h0);
    check("rst_chan", 32'(upd_chan), 32'h0);

    // 1: IDCODE read after reset.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, d, oe);
    check("t1_tlr", 32'(tap_state), 32'hF);
    step(1'b0, 1'b0, d, oe);
    check("t1_rti", 32'(tap_state), 32'hC);
    cap0 = cap_n; upd0 = upd_n;
    shift_dr(32'h0, 32, out, oe_in, oe_out);
    check("t1_idcode", out, 32'h0A001093);
    check("t1_oe_in", 32'(oe_in), 32'h1);
    check("t1_oe_out", 32'(oe_out), 32'h0);
    check("t1_no_upd", 32'(upd_n - upd0), 32'h0);
    check("t1_no_cap", 32'(cap_n - cap0), 32'h0);

    // 2: user channel 2 capture and update.
    cap_data[2*DR_W +: DR_W] = 32'hDEADBEEF;
    shift_ir(6'd4, ir_out);
    check("t2_ir_cap", 32'(ir_out), 32'h01);
    cap0 = cap_n; upd0 = upd_n;
    shift_dr(32'h12345678, 32, out, oe_in, oe_out);
    check("t2_tdo", out, 32'hDEADBEEF);
    check("t2_cap_n", 32'(cap_n - cap0), 32'h1);
    check("t2_cap_vec", 32'(cap_last), 32'h4);
    check("t2_upd_n", 32'(upd_n - upd0), 32'h1);
    check("t2_upd_chan", 32'(upd_chan), 32'h2);
    check("t2_upd_data", upd_data, 32'h12345678);
    check("t2_rti", 32'(tap_state), 32'hC);

    // 3: all-ones IR selects BYPASS; tdo is 0 then tdi delayed one tck.
    shift_ir(6'h3F, ir_out);
    cap0 = cap_n; upd0 = upd_n;
    shift_dr(32'hA5, 8, out, oe_in, oe_out);
    check("t3_bypass", out & 32'hFF, 32'h4A);
    check("t3_no_cap", 32'(cap_n - cap0), 32'h0);
    check("t3_no_upd", 32'(upd_n - upd0), 32'h0);

    // 4: IR capture pattern, then an out-of-range user code (+5; +7 would alias IDCODE).
    shift_ir(6'd7, ir_out);
    check("t4_ir_cap", 32'(ir_out), 32'h01);
    cap0 = cap_n; upd0 = upd_n;
    shift_dr(32'hD, 4, out, oe_in, oe_out);
    check("t4_bypass", out & 32'hF, 32'hA);
    check("t4_no_cap", 32'(cap_n - cap0), 32'h0);
    check("t4_no_upd", 32'(upd_n - upd0), 32'h0);

    // Early exit from Shift-DR publishes the partially shifted channel 1 register.
    cap_data[1*DR_W +: DR_W] = 32'hCAFEF00D;
    shift_ir(6'd3, ir_out);
    upd0 = upd_n;
    shift_dr(32'h5, 3, out, oe_in, oe_out);
    check("early_tdo", out & 32'h7, 32'h5);
    check("early_upd_n", 32'(upd_n - upd0), 32'h1);
    check("early_upd_data", upd_data, 32'hB95FDE01);
    check("early_upd_chan", 32'(upd_chan), 32'h1);

    // 5: reset in the middle of a channel 0 shift, released with tck held high.
    cap_data[0 +: DR_W] = 32'h55AA55AA;
    shift_ir(6'd2, ir_out);
    upd0 = upd_n;
    step(1'b1, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
    step(1'b0, 1'b0, d, oe);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, d, oe);
    check("t5_pre_shift", 32'(tap_state), 32'h2);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("t5_rst_state", 32'(tap_state), 32'hF);
    check("t5_rst_tdo", 32'(jtag.tdo), 32'h0);
    check("t5_rst_oe", 32'(jtag.tdo_oe), 32'h0);
    check("t5_rst_upd", upd_data, 32'h0);
    jtag.tms = 1'b0;
    jtag.tck = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("t5_no_advance", 32'(tap_state), 32'hF);
    check("t5_no_updv", 32'(upd_n - upd0), 32'h0);
    jtag.tck = 1'b0;
    model_fall();
    repeat (HALF) @(negedge clk);
    step(1'b0, 1'b0, d, oe);
    check("t5_rti", 32'(tap_state), 32'hC);
    shift_dr(32'h0, 32, out, oe_in, oe_out);
    check("t5_ir_idcode", out, 32'h0A001093);

    // 6: random walk against the model, starting with channel 1 selected.
    cap_data = {32'h13572468, 32'h89ABCDEF, 32'h0F1E2D3C, 32'hF00DFACE};
    shift_ir(6'd3, ir_out);
    for (int i = 0; i < 150; i++) rstep(i, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    check("rnd_upd_count", 32'(upd_n), 32'(m_upd_n));
    for (int i = 0; i < NCH; i++)
      check($sformatf("rnd_cap_count%0d", i), 32'(cap_ch_n[i]), 32'(m_cap_n[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
